// File: rtl/ts_sync_lock_pkg.sv
// Shared definitions for the MPEG-2 TS packet synchronizer: framing constants,
// FSM state encoding and the error-counter type.
package ts_defs;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         ERR_W        = 8;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef logic [ERR_W-1:0] err_cnt_t;
endpackage

// File: rtl/ts_sync_lock_if.sv
// Byte-stream bundle between a channel input, the synchronizer and the channel FIFO.
interface ts_sync_lock_if #(parameter int DATA_WIDTH = 8);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] ts_data_in;
  logic                  valid_out;
  logic                  sync_out;
  logic [DATA_WIDTH-1:0] ts_data_out;

  modport master (output valid_in, ts_data_in, input valid_out, sync_out, ts_data_out);
  modport slave  (input valid_in, ts_data_in, output valid_out, sync_out, ts_data_out);
endinterface

// File: rtl/ts_silence_timer.sv
// Input-activity watchdog: tracks idle cycles since the last valid byte and
// flags the channel absent once SILENCE_CYCLES idle cycles have elapsed.
module ts_silence_timer #(
  parameter int SILENCE_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  output logic signal_present,
  output logic silence_evt
);
  localparam int            CW    = $clog2(SILENCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(SILENCE_CYCLES);

  logic [CW-1:0] cnt;

  // Combinational so the FSM drops lock on the same edge signal_present falls.
  assign silence_evt = !valid_in && (cnt == LIMIT - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= LIMIT;
      signal_present <= 1'b0;
    end else begin
      if (valid_in)          cnt <= '0;
      else if (cnt != LIMIT) cnt <= cnt + 1'b1;

      if (valid_in)         signal_present <= 1'b1;
      else if (silence_evt) signal_present <= 1'b0;
    end
  end
endmodule

// File: rtl/ts_sync_lock.sv
// Per-channel TS packet synchronizer: hunts for the sync byte, confirms 188-byte
// framing, forwards whole packets once locked and drops packets with a bad sync byte.
module ts_sync_lock
  import ts_defs::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    PKT_LEN        = TS_PKT_LEN,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(TS_SYNC_BYTE),
  parameter int                    LOCK_COUNT     = 3,
  parameter int                    UNLOCK_COUNT   = 3,
  parameter int                    SILENCE_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  ts_sync_lock_if.slave   stream,
  input  logic            error_clr,
  output logic            locked,
  output logic            signal_present,
  output err_cnt_t        error_count
);
  localparam int               IDX_W    = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam logic [7:0]       LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0]       UNLOCK_N = 8'(UNLOCK_COUNT);

  logic [1:0]       state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       good, good_nx, bad, bad_nx;
  logic             drop, drop_nx;
  logic             fwd, sop, err_inc, is_sync, silence_evt;

  ts_silence_timer #(.SILENCE_CYCLES(SILENCE_CYCLES)) u_silence (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (stream.valid_in),
    .signal_present (signal_present),
    .silence_evt    (silence_evt)
  );

  assign is_sync = (stream.ts_data_in == SYNC_BYTE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_nx = state;
    idx_nx   = idx;
    good_nx  = good;
    bad_nx   = bad;
    drop_nx  = drop;
    fwd      = 1'b0;
    sop      = 1'b0;
    err_inc  = 1'b0;

    if (silence_evt) begin
      state_nx = ST_HUNT;
      idx_nx   = '0;
      good_nx  = '0;
      bad_nx   = '0;
      drop_nx  = 1'b0;
    end else if (stream.valid_in) begin
      idx_nx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      case (state)
        ST_HUNT: begin
          idx_nx = '0;
          if (is_sync) begin
            state_nx = ST_VERIFY;
            idx_nx   = IDX_W'(1);
            good_nx  = 8'd1;
          end
        end
        ST_VERIFY: begin
          if (idx == '0) begin
            if (is_sync) begin
              good_nx = good + 1'b1;
              if (good_nx == LOCK_N) begin
                // The byte that completes the lock is the first forwarded byte.
                state_nx = ST_LOCKED;
                bad_nx   = '0;
                drop_nx  = 1'b0;
                fwd      = 1'b1;
                sop      = 1'b1;
              end
            end else begin
              state_nx = ST_HUNT;
              idx_nx   = '0;
              good_nx  = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (idx == '0) begin
            if (is_sync) begin
              bad_nx  = '0;
              drop_nx = 1'b0;
              fwd     = 1'b1;
              sop     = 1'b1;
            end else begin
              err_inc = 1'b1;
              bad_nx  = bad + 1'b1;
              drop_nx = 1'b1;
              if (bad_nx == UNLOCK_N) begin
                state_nx = ST_HUNT;
                idx_nx   = '0;
                good_nx  = '0;
                bad_nx   = '0;
                drop_nx  = 1'b0;
              end
            end
          end else begin
            fwd = !drop;
          end
        end
        default: state_nx = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_HUNT;
      idx                <= '0;
      good               <= '0;
      bad                <= '0;
      drop               <= 1'b0;
      locked             <= 1'b0;
      error_count        <= '0;
      stream.valid_out   <= 1'b0;
      stream.sync_out    <= 1'b0;
      stream.ts_data_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state            <= state_nx;
      idx              <= idx_nx;
      good             <= good_nx;
      bad              <= bad_nx;
      drop             <= drop_nx;
      locked           <= (state_nx == ST_LOCKED);
      stream.valid_out <= fwd;
      stream.sync_out  <= sop;
      if (fwd) stream.ts_data_out <= stream.ts_data_in;

      if (error_clr)                        error_count <= '0;
      else if (err_inc && error_count != '1) error_count <= error_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed self-checking bench for ts_sync_lock; a second short-packet instance
// exercises error-counter saturation within a small cycle budget.
module tb_ts_sync_lock;
  import ts_defs::*;

  localparam int PKT   = 188;
  localparam int PKT_S = 8;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     error_clr, error_clr_s;
  logic     locked, locked_s, signal_present, signal_present_s;
  err_cnt_t error_count, error_count_s;

  int n_chk = 0, n_bad = 0;
  int fwd_cnt = 0, sop_cnt = 0, base_fwd, base_sop;

  always #5 clk = ~clk;

  ts_sync_lock_if #(.DATA_WIDTH(8)) bus ();
  ts_sync_lock_if #(.DATA_WIDTH(8)) bus_s ();

  ts_sync_lock dut (
    .clk(clk), .rst_n(rst_n), .stream(bus), .error_clr(error_clr),
    .locked(locked), .signal_present(signal_present), .error_count(error_count)
  );

  ts_sync_lock #(.PKT_LEN(PKT_S), .SILENCE_CYCLES(64)) dut_s (
    .clk(clk), .rst_n(rst_n), .stream(bus_s), .error_clr(error_clr_s),
    .locked(locked_s), .signal_present(signal_present_s), .error_count(error_count_s)
  );

  always @(negedge clk) begin
    if (bus.valid_out) begin
      fwd_cnt++;
      if (bus.sync_out) sop_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int i);
    return 8'(i % 64);
  endfunction

  task automatic tick(input logic v, input logic [7:0] d);
    bus.valid_in   = v;
    bus.ts_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic send_body(input int from, input int upto);
    for (int i = from; i <= upto; i++) tick(1'b1, pay(i));
  endtask

  task automatic send_pkt(input logic [7:0] s);
    tick(1'b1, s);
    send_body(1, PKT - 1);
  endtask

  task automatic tick_s(input logic v, input logic [7:0] d);
    bus_s.valid_in   = v;
    bus_s.ts_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pkt_s(input logic [7:0] s);
    tick_s(1'b1, s);
    for (int i = 1; i < PKT_S; i++) tick_s(1'b1, pay(i));
  endtask

  task automatic snap();
    base_fwd = fwd_cnt;
    base_sop = sop_cnt;
  endtask

  initial begin
    rst_n = 1'b0; error_clr = 1'b0; error_clr_s = 1'b0;
    bus.valid_in = 1'b0; bus.ts_data_in = '0;
    bus_s.valid_in = 1'b0; bus_s.ts_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_sync_out", bus.sync_out, 0);
    check("rst_data_out", bus.ts_data_out, 0);
    check("rst_locked", locked, 0);
    check("rst_present", signal_present, 0);
    check("rst_err", error_count, 0);
    rst_n = 1'b1;

    // Clean stream: lock on the third sync byte (byte 376), then 8 packets out.
    snap();
    send_pkt(8'h47);
    send_pkt(8'h47);
    check("clean_no_lock_yet", locked, 0);
    check("clean_no_fwd_yet", fwd_cnt - base_fwd, 0);
    tick(1'b1, 8'h47);
    check("clean_lock_rise", locked, 1);
    check("clean_first_valid", bus.valid_out, 1);
    check("clean_first_sop", bus.sync_out, 1);
    check("clean_first_byte", bus.ts_data_out, 8'h47);
    tick(1'b1, pay(1));
    check("clean_byte1_data", bus.ts_data_out, pay(1));
    check("clean_byte1_nosop", bus.sync_out, 0);
    send_body(2, PKT - 1);
    for (int p = 3; p < 10; p++) send_pkt(8'h47);
    idle(1);
    check("clean_fwd_bytes", fwd_cnt - base_fwd, 8 * PKT);
    check("clean_fwd_pkts", sop_cnt - base_sop, 8);
    check("clean_err", error_count, 0);
    check("clean_present", signal_present, 1);

    // One corrupted sync byte: packet dropped, lock kept, next packet forwarded.
    snap();
    send_pkt(8'h00);
    idle(1);
    check("corrupt_suppressed", fwd_cnt - base_fwd, 0);
    check("corrupt_err", error_count, 1);
    check("corrupt_locked", locked, 1);
    snap();
    tick(1'b1, 8'h47);
    check("after_corrupt_sop", bus.sync_out, 1);
    send_body(1, PKT - 1);
    idle(1);
    check("after_corrupt_fwd", fwd_cnt - base_fwd, PKT);

    // Three consecutive bad sync bytes drop lock; three good ones re-lock.
    error_clr = 1'b1;
    idle(1);
    error_clr = 1'b0;
    check("clr_err", error_count, 0);
    snap();
    send_pkt(8'h00);
    send_pkt(8'h00);
    check("bad2_locked", locked, 1);
    check("bad2_err", error_count, 2);
    tick(1'b1, 8'h00);
    check("bad3_unlock", locked, 0);
    check("bad3_err", error_count, 3);
    check("bad3_not_fwd", bus.valid_out, 0);
    send_body(1, PKT - 1);
    send_pkt(8'h47);
    send_pkt(8'h47);
    check("relock_pending", locked, 0);
    check("relock_no_fwd", fwd_cnt - base_fwd, 0);
    tick(1'b1, 8'h47);
    check("relock_rise", locked, 1);
    check("relock_sop", bus.sync_out, 1);
    send_body(1, PKT - 1);

    // Reset at byte 90 of a locked packet aborts at once; re-lock is required.
    tick(1'b1, 8'h47);
    send_body(1, 89);
    bus.valid_in = 1'b1;
    bus.ts_data_in = pay(90);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", bus.valid_out, 0);
    check("midrst_locked", locked, 0);
    check("midrst_err", error_count, 0);
    check("midrst_present", signal_present, 0);
    @(posedge clk);
    #1;
    check("midrst_next_cycle", {bus.valid_out, bus.sync_out, bus.ts_data_out, locked}, 0);
    rst_n = 1'b1;
    snap();
    send_pkt(8'h47);
    send_pkt(8'h47);
    idle(1);
    check("postrst_no_fwd", fwd_cnt - base_fwd, 0);
    check("postrst_unlocked", locked, 0);
    tick(1'b1, 8'h47);
    check("postrst_lock", locked, 1);
    send_body(1, PKT - 1);

    // Stray sync byte at byte 50 during HUNT: no sync 188 bytes later.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    snap();
    send_body(0, 49);
    tick(1'b1, 8'h47);
    for (int i = 51; i < 51 + PKT - 1; i++) tick(1'b1, pay(i));
    tick(1'b1, 8'h00);
    check("stray_unlocked", locked, 0);
    check("stray_no_fwd", fwd_cnt - base_fwd, 0);
    send_pkt(8'h47);
    send_pkt(8'h47);
    check("stray_relock_pending", locked, 0);
    tick(1'b1, 8'h47);
    check("stray_relock", locked, 1);
    check("stray_relock_sop", bus.sync_out, 1);
    send_body(1, PKT - 1);

    // Silence: a 4095-cycle gap keeps lock, a 4096-cycle gap drops it.
    send_pkt(8'h00);
    send_pkt(8'h47);
    check("sil_err_setup", error_count, 1);
    idle(4095);
    check("gap4095_present", signal_present, 1);
    check("gap4095_locked", locked, 1);
    snap();
    send_pkt(8'h47);
    check("gap4095_framing", sop_cnt - base_sop, 1);
    idle(4095);
    check("gap_pre_present", signal_present, 1);
    idle(1);
    check("sil_present_fall", signal_present, 0);
    check("sil_locked_fall", locked, 0);
    check("sil_err_kept", error_count, 1);
    snap();
    send_pkt(8'h47);
    idle(1);
    check("sil_after_present", signal_present, 1);
    check("sil_after_hunt", fwd_cnt - base_fwd, 0);

    // Short-packet instance: saturation at 255 and clear priority.
    for (int p = 0; p < 3; p++) pkt_s(8'h47);
    check("sat_locked", locked_s, 1);
    for (int r = 0; r < 128; r++) begin
      pkt_s(8'h00);
      pkt_s(8'h00);
      pkt_s(8'h47);
    end
    check("sat_err_255", error_count_s, 255);
    check("sat_still_locked", locked_s, 1);
    pkt_s(8'h00);
    check("sat_stays_255", error_count_s, 255);
    error_clr_s = 1'b1;
    tick_s(1'b1, 8'h00);
    error_clr_s = 1'b0;
    check("clr_beats_inc", error_count_s, 0);
    check("clr_locked", locked_s, 1);
    for (int i = 1; i < PKT_S; i++) tick_s(1'b1, pay(i));
    tick_s(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/ts_sync_lock.md
# ts_sync_lock

Per-channel MPEG-2 TS packet synchronizer placed between each channel input (`ts_dataN`/`validN`) and that channel's write-side FIFO inside `top_QoS`. It hunts for the 0x47 sync byte and confirms 188-byte packet framing. Once locked, it forwards whole packets with a start-of-packet flag and drops packets whose sync byte is corrupted. It reports lock, signal presence and a saturating error count that feeds the `error_count_chN` fields of config register 0x02.

## Interface
- `DATA_WIDTH`, 8, byte width
- `PKT_LEN`, 188, packet length in bytes
- `SYNC_BYTE`, 8'h47, sync byte value
- `LOCK_COUNT`, 3, consecutive good sync bytes needed to lock (≥2)
- `UNLOCK_COUNT`, 3, consecutive bad sync bytes needed to drop lock (≥1)
- `SILENCE_CYCLES`, 4096, idle `clk` cycles after which the signal is declared absent
- `clk`  in  1  single clock (the channel's `wclkN`)
- `rst_n`  in  1  asynchronous, active-low reset
- `valid_in`  in  1  input byte strobe
- `ts_data_in`  in  DATA_WIDTH  input byte
- `error_clr`  in  1  one-cycle pulse; clears `error_count`
- `valid_out`  out  1  forwarded byte strobe
- `sync_out`  out  1  high with the first byte (0x47) of each forwarded packet
- `ts_data_out`  out  DATA_WIDTH  forwarded byte
- `locked`  out  1  state is LOCKED
- `signal_present`  out  1  input activity seen within the last `SILENCE_CYCLES`
- `error_count`  out  8  count of lost packets; saturates at 255

## Operation
- `idx` is the byte position, 0..PKT_LEN-1. It advances only on `valid_in` and wraps from 187 to 0.
- State machine:
  - HUNT: `idx` is ignored. A valid byte equal to SYNC_BYTE moves to VERIFY with `idx`=1 and `good`=1.
  - VERIFY: at each valid byte with `idx`==0, a sync match increments `good`. When `good` reaches LOCK_COUNT, go to LOCKED. A mismatch at `idx`==0 returns to HUNT, and the same byte is not re-evaluated as a new hunt candidate.
  - LOCKED, packet start (valid byte with `idx`==0):
    - Sync match: clear `bad`, set `drop`=0.
    - Mismatch: `error_count`+1, `bad`+1, set `drop`=1 for the whole packet.
    - If `bad` reaches UNLOCK_COUNT, go to HUNT; `locked` falls.
- Forwarding happens only in LOCKED, or on the byte that completes the lock, and only when `drop`=0.
- `sync_out` is asserted on forwarded bytes with `idx`==0.
- Bytes received in HUNT or VERIFY are never forwarded, except the byte that completes the lock.
- Silence handling:
  - A counter clears on `valid_in` and increments otherwise, saturating at SILENCE_CYCLES.
  - When it reaches SILENCE_CYCLES: `signal_present`=0, state goes to HUNT, and `idx`, `good` and `bad` are cleared. `error_count` is not incremented.
  - `signal_present` sets on any `valid_in`.
- `error_count` is 8 bits and sticks at 255. `error_clr` has priority over a simultaneous increment; the result is 0.

## Timing
- All outputs are registered. Data path latency is 1 cycle: `ts_data_out`/`valid_out`/`sync_out` at cycle n+1 reflect the input at cycle n.
- The lock decision and the first forwarded byte are the same byte: the LOCK_COUNT-th sync byte is output with `sync_out`=1. `locked` rises in the same cycle.
- Unlock: the UNLOCK_COUNT-th bad sync byte is not forwarded. `locked` falls one cycle after that byte is sampled.
- Silence: `signal_present` falls exactly SILENCE_CYCLES cycles after the last `valid_in` cycle.
- Reset values: `valid_out`=0, `sync_out`=0, `ts_data_out`=0, `locked`=0, `signal_present`=0, `error_count`=0; state HUNT, `idx`=0, `drop`=0.
- Reset asserted mid-packet aborts immediately. After release, forwarding requires a full re-lock.
- `valid_in` gaps of any length shorter than SILENCE_CYCLES do not disturb framing.

## Structure
- Shared package/header `ts_defs`: SYNC_BYTE, PKT_LEN, the state encoding (HUNT=0, VERIFY=1, LOCKED=2), and the error-count width (8).
- One sub-module, `ts_silence_timer`:
  - Inputs: `clk`, `rst_n`, `valid_in`.
  - Output: `signal_present` plus a one-cycle `silence_evt` pulse.
  - Parameter: `SILENCE_CYCLES`.
- The FSM, position counter and error counter stay in `ts_sync_lock`.

## Test plan
- Clean stream: 10 packets with 0x47 at 188-byte spacing, continuous `valid_in`.
  - `locked` rises on the 3rd sync byte (byte 376).
  - First `valid_out` byte is 0x47 with `sync_out`=1.
  - Exactly 8 packets forwarded; `error_count`=0.
- Lock, then corrupt one sync byte (0x00) of packet 5.
  - Packet 5 is fully suppressed (188 bytes with no `valid_out`).
  - `error_count`=1, `locked` stays 1, packet 6 is forwarded.
- Three consecutive corrupted sync bytes while locked.
  - `error_count`=3 and `locked` falls after the third.
  - Clean traffic re-locks after 3 good sync bytes.
- Stray 0x47 at byte 50 while in HUNT, no sync 188 bytes later.
  - Returns to HUNT; no output.
  - Real alignment then locks normally.
- Lock, then hold `valid_in`=0 for 4096 cycles.
  - `signal_present` falls at cycle 4096 and `locked` falls.
  - `error_count` is unchanged.
  - A gap of 4095 cycles keeps lock.
- `error_count` at 255 plus another bad packet: stays 255. `error_clr` coincident with a bad sync byte: 0. Reset asserted at byte 90 of a packet: all outputs 0 next cycle.
